// File: rtl/par_ser_param.sv
// par_ser_param -- parametrised parallel-to-serial converter.
//
// Accepts a WIDTH-bit word on a strobe/ready handshake. It then shifts the
// word out on d_out at one bit per clock, MSB- or LSB-first. An even or odd
// parity bit can optionally follow the data bits. A new word offered during
// the last bit of a frame follows with no idle gap.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   strobe : load request
//   d_in   : parallel word, captured when strobe && ready
//   ready  : a word can be accepted on the coming edge
//   d_out  : registered serial data (IDLE_LEVEL when no frame is active)
//   frame  : high while a data or parity bit is on d_out
//   done   : high during the last bit of a frame
module par_ser_param #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [WIDTH-1:0] d_in,
  output logic             ready,
  output logic             d_out,
  output logic             frame,
  output logic             done
);

  // Frame length and bit-index encodings.
  localparam int unsigned N        = WIDTH + (PARITY_EN ? 32'd1 : 32'd0);
  localparam int unsigned CW       = $clog2(N + 32'd1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 32'd1);
  localparam logic [CW-1:0] PAR_IDX  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             is_last;
  logic [CW-1:0]    cnt_inc;
  logic             first_bit;
  logic [WIDTH-1:0] load_shreg;
  logic             next_bit;
  logic [WIDTH-1:0] next_shreg;

  // Parity of a data word; odd parity is the inverted XOR.
  function automatic logic calc_parity(input logic [WIDTH-1:0] w);
    return (^w) ^ PARITY_ODD;
  endfunction

  assign accept  = strobe & ready;
  assign is_last = (cnt == LAST_IDX);
  assign cnt_inc = cnt + CW'(1);

  // Bit selection: the first bit goes straight to d_out on accept. The
  // shift register therefore holds the remaining bits pre-shifted, so the
  // next bit is always at the outgoing end.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = d_in[WIDTH-1];
      load_shreg = {d_in[WIDTH-2:0], 1'b0};
      next_bit   = shreg[WIDTH-1];
      next_shreg = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      first_bit  = d_in[0];
      load_shreg = {1'b0, d_in[WIDTH-1:1]};
      next_bit   = shreg[0];
      next_shreg = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // Frame state machine with registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      par_bit <= 1'b0;
      cnt     <= '0;
      d_out   <= IDLE_LEVEL;
      frame   <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else if (accept) begin
      // ready is only high in IDLE or the last-bit cycle, so this also
      // covers the back-to-back case.
      state   <= SHIFT;
      shreg   <= load_shreg;
      par_bit <= calc_parity(d_in);
      cnt     <= '0;
      d_out   <= first_bit;
      frame   <= 1'b1;
      done    <= 1'b0;   // N >= 2, so bit 0 is never the last bit
      ready   <= 1'b0;
    end else begin
      case (state)
        SHIFT, PAR: begin
          if (is_last) begin
            state <= IDLE;
            cnt   <= '0;
            d_out <= IDLE_LEVEL;
            frame <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
          end else begin
            cnt   <= cnt_inc;
            frame <= 1'b1;
            done  <= (cnt_inc == LAST_IDX);
            ready <= (cnt_inc == LAST_IDX);
            if (PARITY_EN && (cnt_inc == PAR_IDX)) begin
              state <= PAR;
              d_out <= par_bit;
            end else begin
              state <= SHIFT;
              d_out <= next_bit;
              shreg <= next_shreg;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          d_out <= IDLE_LEVEL;
          frame <= 1'b0;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_ser_param.sv
// Testbench for par_ser_param. Four configurations share one clock:
//   0: WIDTH 8, MSB-first, no parity, idle 0
//   1: WIDTH 8, LSB-first, even parity
//   2: WIDTH 8, LSB-first, odd parity
//   3: WIDTH 4, MSB-first, no parity, idle 1
// The reference model is a queue of the bits still to be sent.
module tb_par_ser_param;

  logic        clk;
  logic        rst;
  logic        strb [4];
  logic [63:0] din  [4];
  logic [3:0]  dout, frm, dn, rdy;

  int wd   [4] = '{8, 8, 8, 4};
  bit msbf [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit pen  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit podd [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit idl  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  int n_pass  = 0;
  int n_total = 0;

  bit mq [$];
  bit e_dout, e_frame, e_done, e_ready;

  par_ser_param #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .strobe(strb[0]), .d_in(din[0][7:0]),
    .ready(rdy[0]), .d_out(dout[0]), .frame(frm[0]), .done(dn[0]));
  par_ser_param #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst(rst), .strobe(strb[1]), .d_in(din[1][7:0]),
    .ready(rdy[1]), .d_out(dout[1]), .frame(frm[1]), .done(dn[1]));
  par_ser_param #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst(rst), .strobe(strb[2]), .d_in(din[2][7:0]),
    .ready(rdy[2]), .d_out(dout[2]), .frame(frm[2]), .done(dn[2]));
  par_ser_param #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .IDLE_LEVEL(1'b1)) u3 (
    .clk(clk), .rst(rst), .strobe(strb[3]), .d_in(din[3][3:0]),
    .ready(rdy[3]), .d_out(dout[3]), .frame(frm[3]), .done(dn[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a few thousand cycles at most.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required a finished run");
    $fatal(1, "watchdog");
  end

  // Build the full frame for a word: data bits in send order, then parity.
  task automatic load_model(input int i, input logic [63:0] word);
    bit p;
    mq.delete();
    p = podd[i];
    for (int k = 0; k < wd[i]; k++) begin
      mq.push_back(msbf[i] ? word[wd[i]-1-k] : word[k]);
      p = p ^ word[k];
    end
    if (pen[i]) mq.push_back(p);
  endtask

  task automatic drive(input int i, input logic s, input logic [63:0] word);
    strb[i] = s;
    din[i]  = word;
  endtask

  // One clock: the model accepts when at most one bit remains; expected
  // outputs are then derived from what is left in the queue.
  task automatic tick(input int i);
    bit acc;
    acc = strb[i] && (mq.size() <= 1);
    @(posedge clk);
    if (acc) load_model(i, din[i]);
    else if (mq.size() > 0) void'(mq.pop_front());
    #1;
    if (mq.size() > 0) begin
      e_dout  = mq[0];
      e_frame = 1'b1;
      e_done  = (mq.size() == 1);
      e_ready = (mq.size() == 1);
    end else begin
      e_dout  = idl[i];
      e_frame = 1'b0;
      e_done  = 1'b0;
      e_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 64'd0);
    #12;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({dout[i], frm[i], dn[i], rdy[i]} !== {idl[i], 1'b0, 1'b0, 1'b1})
        $display("FAIL reset inst %0d: got dout/frame/done/ready=%b required=%b",
                 i, {dout[i], frm[i], dn[i], rdy[i]}, {idl[i], 3'b001});
      else n_pass++;
    end
    rst = 1'b0;
    mq.delete();
    @(posedge clk); #1;
  endtask

  // Single frames of fixed words, one-cycle strobe, run until idle.
  task automatic test_single(input int i, input logic [63:0] word, input string name);
    drive(i, 1'b1, word);
    for (int c = 1; c <= wd[i] + 3; c++) begin
      tick(i);
      drive(i, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      n_total++;
      if ({dout[i], frm[i], dn[i], rdy[i]} !== {e_dout, e_frame, e_done, e_ready})
        $display("FAIL %s inst %0d cycle %0d: got dout/frame/done/ready=%b required=%b",
                 name, i, c, {dout[i], frm[i], dn[i], rdy[i]}, {e_dout, e_frame, e_done, e_ready});
      else n_pass++;
    end
  endtask

  // 8'hF0 then 8'h0F offered in the last-bit cycle: 16 contiguous bits.
  task automatic test_back_to_back();
    logic [15:0] got;
    drive(0, 1'b1, 64'hF0);
    for (int c = 1; c <= 18; c++) begin
      tick(0);
      drive(0, (c == 8), (c == 8) ? 64'h0F : 64'hAA);
      if (c <= 16) got[16-c] = dout[0];
      n_total++;
      if ({dout[0], frm[0], dn[0], rdy[0]} !== {e_dout, e_frame, e_done, e_ready})
        $display("FAIL back_to_back cycle %0d: got dout/frame/done/ready=%b required=%b",
                 c, {dout[0], frm[0], dn[0], rdy[0]}, {e_dout, e_frame, e_done, e_ready});
      else n_pass++;
    end
    n_total++;
    if (got !== 16'b1111000000001111)
      $display("FAIL back_to_back_stream: got %b required %b", got, 16'b1111000000001111);
    else n_pass++;
  endtask

  // Strobe with 8'hFF during cycles 3..5 of an 8'h00 frame is ignored.
  task automatic test_ignored_strobe();
    drive(0, 1'b1, 64'h00);
    for (int c = 1; c <= 11; c++) begin
      tick(0);
      drive(0, (c >= 2 && c <= 4), 64'hFF);
      n_total++;
      if ({dout[0], frm[0], dn[0], rdy[0]} !== {e_dout, e_frame, e_done, e_ready})
        $display("FAIL ignored_strobe cycle %0d: got dout/frame/done/ready=%b required=%b",
                 c, {dout[0], frm[0], dn[0], rdy[0]}, {e_dout, e_frame, e_done, e_ready});
      else n_pass++;
    end
    drive(0, 1'b0, 64'h00);
  endtask

  // Asynchronous reset during bit 3 of 8'hAA, then a clean 8'h55 frame.
  task automatic test_reset_mid_frame();
    drive(0, 1'b1, 64'hAA);
    tick(0);
    drive(0, 1'b0, 64'h00);
    tick(0);
    tick(0);
    #3;
    rst = 1'b1;
    #1;
    mq.delete();
    n_total++;
    if ({dout[0], frm[0], dn[0], rdy[0]} !== 4'b0001)
      $display("FAIL reset_mid_frame: got dout/frame/done/ready=%b required=%b",
               {dout[0], frm[0], dn[0], rdy[0]}, 4'b0001);
    else n_pass++;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    test_single(0, 64'h55, "after_reset");
  endtask

  // Random words and strobes, d_in changing every cycle.
  task automatic test_random(input int i);
    logic [63:0] mask;
    mask = (64'd1 << wd[i]) - 64'd1;
    for (int c = 0; c < 200; c++) begin
      drive(i, ($urandom_range(0, 3) != 0), {$urandom, $urandom} & mask);
      tick(i);
      n_total++;
      if ({dout[i], frm[i], dn[i], rdy[i]} !== {e_dout, e_frame, e_done, e_ready})
        $display("FAIL random inst %0d cycle %0d: got dout/frame/done/ready=%b required=%b",
                 i, c, {dout[i], frm[i], dn[i], rdy[i]}, {e_dout, e_frame, e_done, e_ready});
      else n_pass++;
    end
    drive(i, 1'b0, 64'd0);
    for (int c = 0; c < 12; c++) tick(i);
  endtask

  initial begin
    test_reset();
    test_single(0, 64'hAA, "msb_first");
    test_single(1, 64'hAA, "lsb_even_parity");
    test_single(1, 64'hA1, "lsb_even_parity");
    test_single(2, 64'hA1, "lsb_odd_parity");
    test_back_to_back();
    test_ignored_strobe();
    test_reset_mid_frame();
    test_single(3, 64'h3, "width4_idle_high");
    for (int i = 0; i < 4; i++) test_random(i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/par_ser_param.md
Name: par_ser_param

Overview:
Parametrised parallel-to-serial converter, the successor to the fixed 8-bit par_ser.
- Loads a WIDTH-bit word on a strobe/ready handshake.
- Shifts the word out one bit per clock, MSB- or LSB-first, with an optional parity bit.
- Supports back-to-back frames with no idle gap.
- Sits between a parallel data source and a single-wire serial link or serial test stimulus path.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..64.
MSB_FIRST, 1, 1 = d_in[WIDTH-1] is sent first; 0 = d_in[0] is sent first.
PARITY_EN, 0, 1 = append one parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity (XOR of data bits); 1 = odd parity (inverted XOR). Ignored when PARITY_EN=0.
IDLE_LEVEL, 0, value driven on d_out when no frame is active.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
strobe  input  1  load request; sampled on the rising clk edge.
d_in  input  WIDTH  parallel word; captured when strobe and ready are both high.
ready  output  1  block can accept a word on this edge.
d_out  output  1  serial data, registered.
frame  output  1  high while a data or parity bit is on d_out.
done  output  1  one-cycle pulse, high during the last bit of a frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock needed): d_out=IDLE_LEVEL, frame=0, done=0, ready=1, state=IDLE, bit counter=0, shift register=0.
- Frame length: N = WIDTH + PARITY_EN bits.
- State machine:
  - IDLE: ready=1, frame=0, d_out=IDLE_LEVEL.
  - SHIFT: data bits are on d_out.
  - PAR: parity bit is on d_out; this state exists only when PARITY_EN=1.
- Accept: on an edge with strobe=1 and ready=1:
  - d_in is captured.
  - Parity is computed from d_in at capture time.
  - State goes to SHIFT and the bit counter is set to 0.
- Latency: the first bit is on d_out in the cycle immediately after the accept edge. Each bit is held for exactly one clock.
- Bit order:
  - Bit k of the frame (k=0..WIDTH-1) is d_in[WIDTH-1-k] when MSB_FIRST=1, and d_in[k] when MSB_FIRST=0.
  - When PARITY_EN=1, bit WIDTH of the frame is the parity bit.
- State transitions:
  - SHIFT advances to PAR (PARITY_EN=1) or ends the frame (PARITY_EN=0) after the WIDTH-th bit.
  - PAR lasts exactly one cycle.
- done=1 only during the cycle in which the last bit of a frame (bit N-1) is on d_out.
- ready=1 in IDLE and during the last-bit cycle; ready=0 during all other frame cycles.
- Back-to-back frames:
  - If strobe=1 on the edge that ends the last-bit cycle, the new word is accepted.
  - Its bit 0 appears in the very next cycle, and frame stays 1 with no gap.
  - Otherwise the state returns to IDLE and d_out=IDLE_LEVEL on that edge.
- Ignored strobes:
  - strobe while ready=0 is ignored; the frame in progress is unaffected and no word is queued.
  - A strobe held high across multiple cycles in IDLE is accepted once, on the first edge. It is accepted again only at the next last-bit cycle.
- d_in is only sampled on accept edges; changes to d_in at any other time have no effect.
- Reset mid-frame aborts the frame immediately and applies the reset values; a partially sent word is never resumed.
- Bit counter width: clog2(N+1). No wrap beyond N-1 is permitted; the counter resets on every accept.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, PARITY_EN=0, d_in=8'hAA, one-cycle strobe at edge t0 -> d_out cycles 1..8 = 1,0,1,0,1,0,1,0; frame=1 in cycles 1..8; done=1 only in cycle 8; ready=0 in cycles 1..7; cycle 9: d_out=0, frame=0.
2. MSB_FIRST=0, d_in=8'hAA -> d_out = 0,1,0,1,0,1,0,1; then PARITY_EN=1, PARITY_ODD=0, d_in=8'hA1 -> 8 data bits, then parity bit 1 in cycle 9 with done=1 in cycle 9; with PARITY_ODD=1 the parity bit is 0.
3. Back-to-back: 8'hF0 accepted at t0, strobe high again with d_in=8'h0F in cycle 8 -> 16 contiguous bits 1111000000001111; frame=1 throughout; done pulses in cycles 8 and 16.
4. Strobe with d_in=8'hFF asserted in cycles 3..5 of an 8'h00 frame -> d_out stays 0 for all 8 bits; no second frame follows; ready=1 from cycle 8.
5. rst asserted asynchronously mid-cycle during bit 3 of 8'hAA -> without waiting for a clock edge, d_out=IDLE_LEVEL, frame=0, ready=1, done=0; after rst is released, a new strobe with 8'h55 gives a clean full frame.
6. WIDTH=4, IDLE_LEVEL=1, d_in=4'b0011 MSB-first -> d_out is 1 before the frame, then 0,0,1,1, then returns to 1; done=1 in cycle 4.
